// File: rtl/store_load_sequencer.sv
// Multicycle sequencer for sized loads and stores: read-modify-write for sub-word
// stores, direct write for word stores, read/latch/writeback for loads.
module store_load_sequencer #(
    parameter int MEM_LAT = 1,
    parameter int CNT_W   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       store_req,
    input  logic       load_req,
    input  logic [1:0] size,
    output logic       busy,
    output logic       done,
    output logic       size_error,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       mdr_wr,
    output logic       reg_wr,
    output logic [1:0] set_store_size_control,
    output logic [1:0] load_size_control,
    output logic [3:0] state_dbg
);

    // Handshake: a request (store_req/load_req) is accepted only while busy is low
    // and is consumed on the accept edge; completion is signalled by a one-cycle
    // done pulse. Requests seen while busy are dropped, never queued.
    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        ST_RD  = 4'd1,
        ST_MDR = 4'd2,
        ST_WR  = 4'd3,
        LD_RD  = 4'd4,
        LD_MDR = 4'd5,
        LD_WB  = 4'd6,
        ERR    = 4'd7,
        DONE   = 4'd8
    } state_t;

    localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(MEM_LAT - 1);

    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       size_q;
    logic             accept;

    assign accept = (state == IDLE) && (store_req || load_req);

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            size_q <= 2'b10;
        end else begin
            state <= state_n;
            if (accept) begin
                size_q <= size;
                cnt    <= '0;
            end else if (state == ST_RD || state == LD_RD) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (store_req || load_req) begin
                    // Store outranks a simultaneous load; size 11 is rejected for either.
                    if (size == 2'b11)       state_n = ERR;
                    else if (store_req)      state_n = (size == 2'b10) ? ST_WR : ST_RD;
                    else                     state_n = LD_RD;
                end
            end
            ST_RD:   if (cnt == LAT_LAST) state_n = ST_MDR;
            ST_MDR:  state_n = ST_WR;
            ST_WR:   state_n = DONE;
            LD_RD:   if (cnt == LAT_LAST) state_n = LD_MDR;
            LD_MDR:  state_n = LD_WB;
            LD_WB:   state_n = DONE;
            ERR:     state_n = IDLE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        busy                   = (state != IDLE);
        done                   = 1'b0;
        size_error             = 1'b0;
        mem_rd                 = 1'b0;
        mem_wr                 = 1'b0;
        mdr_wr                 = 1'b0;
        reg_wr                 = 1'b0;
        set_store_size_control = 2'b00;
        load_size_control      = 2'b00;
        case (state)
            ST_RD, LD_RD: mem_rd = 1'b1;
            ST_MDR: begin
                mdr_wr                 = 1'b1;
                set_store_size_control = size_q;
            end
            ST_WR: begin
                mem_wr                 = 1'b1;
                set_store_size_control = size_q;
            end
            LD_MDR: mdr_wr = 1'b1;
            LD_WB: begin
                reg_wr            = 1'b1;
                load_size_control = size_q;
            end
            ERR: begin
                size_error = 1'b1;
                done       = 1'b1;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_store_load_sequencer.sv
// Directed bench for store_load_sequencer: three instances (MEM_LAT 1, 2, 3)
// checked cycle by cycle against the access timeline of each operation kind.
module tb_store_load_sequencer;

    logic       clk;
    logic       reset;
    logic [2:0] store_req;
    logic [2:0] load_req;
    logic [1:0] size [3];
    logic [2:0] busy, done, size_error, mem_rd, mem_wr, mdr_wr, reg_wr;
    logic [1:0] ssc [3];
    logic [1:0] lsc [3];
    logic [3:0] sdbg [3];
    // {busy, done, size_error, mem_rd, mem_wr, mdr_wr, reg_wr, ssc[1:0], lsc[1:0]}
    logic [10:0] o [3];

    int tests = 0;
    int fails = 0;

    localparam int K_RMW = 0;
    localparam int K_SW  = 1;
    localparam int K_LD  = 2;
    localparam int K_ERR = 3;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        store_load_sequencer #(.MEM_LAT(g + 1), .CNT_W(4)) dut (
            .clk                    (clk),
            .reset                  (reset),
            .store_req              (store_req[g]),
            .load_req               (load_req[g]),
            .size                   (size[g]),
            .busy                   (busy[g]),
            .done                   (done[g]),
            .size_error             (size_error[g]),
            .mem_rd                 (mem_rd[g]),
            .mem_wr                 (mem_wr[g]),
            .mdr_wr                 (mdr_wr[g]),
            .reg_wr                 (reg_wr[g]),
            .set_store_size_control (ssc[g]),
            .load_size_control      (lsc[g]),
            .state_dbg              (sdbg[g])
        );
        assign o[g] = {busy[g], done[g], size_error[g], mem_rd[g], mem_wr[g],
                       mdr_wr[g], reg_wr[g], ssc[g], lsc[g]};
    end

    // Expected outputs in cycle c after the accept edge (cycle 1 = first busy cycle).
    function automatic logic [10:0] exp_out(int kind, int lat, logic [1:0] sz, int c);
        logic [10:0] e;
        e = '0;
        case (kind)
            K_RMW: begin
                if (c >= 1 && c <= lat) begin e[10] = 1'b1; e[7] = 1'b1; end
                else if (c == lat + 1) begin e[10] = 1'b1; e[5] = 1'b1; e[3:2] = sz; end
                else if (c == lat + 2) begin e[10] = 1'b1; e[6] = 1'b1; e[3:2] = sz; end
                else if (c == lat + 3) begin e[10] = 1'b1; e[9] = 1'b1; end
            end
            K_SW: begin
                if (c == 1)      begin e[10] = 1'b1; e[6] = 1'b1; e[3:2] = 2'b10; end
                else if (c == 2) begin e[10] = 1'b1; e[9] = 1'b1; end
            end
            K_LD: begin
                if (c >= 1 && c <= lat) begin e[10] = 1'b1; e[7] = 1'b1; end
                else if (c == lat + 1) begin e[10] = 1'b1; e[5] = 1'b1; end
                else if (c == lat + 2) begin e[10] = 1'b1; e[4] = 1'b1; e[1:0] = sz; end
                else if (c == lat + 3) begin e[10] = 1'b1; e[9] = 1'b1; end
            end
            K_ERR: begin
                if (c == 1) begin e[10] = 1'b1; e[9] = 1'b1; e[8] = 1'b1; end
            end
            default: e = '0;
        endcase
        return e;
    endfunction

    task automatic chk(string tag, int c, logic [10:0] obs, logic [10:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s cycle %0d: observed %b expected %b", tag, c, obs, exp);
        end
    endtask

    task automatic chk_mutex(string tag, int i, int c);
        tests++;
        assert ((mem_rd[i] & mem_wr[i]) === 1'b0) else begin
            fails++;
            $error("FAIL %s cycle %0d: mem_rd&mem_wr observed %b expected 0", tag, c,
                   mem_rd[i] & mem_wr[i]);
        end
    endtask

    // One-cycle request on instance i, then check cycles 1..ncyc. If intr_c > 0 a
    // one-cycle load_req is pulsed starting in that cycle to show it is ignored.
    task automatic run_op(string tag, int i, bit st, bit ld, logic [1:0] sz,
                          int kind, int intr_c, int ncyc);
        @(negedge clk);
        chk({tag, "_pre"}, 0, o[i], 11'b0);
        store_req[i] = st;
        load_req[i]  = ld;
        size[i]      = sz;
        @(posedge clk);
        #1;
        store_req[i] = 1'b0;
        load_req[i]  = 1'b0;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            chk(tag, c, o[i], exp_out(kind, i + 1, sz, c));
            chk_mutex(tag, i, c);
            load_req[i] = (c == intr_c);
        end
        load_req[i] = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        store_req = '0;
        load_req  = '0;
        for (int i = 0; i < 3; i++) size[i] = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("reset_outs", i, o[i], 11'b0);
            chk("reset_state", i, {7'b0, sdbg[i]}, 11'b0);
        end

        run_op("sb_l1",      0, 1'b1, 1'b0, 2'b00, K_RMW, 0, 5);
        run_op("sh_l3",      2, 1'b1, 1'b0, 2'b01, K_RMW, 0, 7);
        run_op("sw_l1",      0, 1'b1, 1'b0, 2'b10, K_SW,  0, 3);
        run_op("st_ld_both", 1, 1'b1, 1'b1, 2'b00, K_RMW, 0, 6);
        run_op("lh_l2",      1, 1'b0, 1'b1, 2'b01, K_LD,  0, 6);
        run_op("ld_lb_l3",   2, 1'b0, 1'b1, 2'b00, K_LD,  0, 7);
        run_op("size_err",   0, 1'b1, 1'b0, 2'b11, K_ERR, 0, 3);
        run_op("ld_err",     1, 1'b0, 1'b1, 2'b11, K_ERR, 0, 2);
        run_op("busy_ignore",2, 1'b1, 1'b0, 2'b00, K_RMW, 2, 9);

        // Reset lands at the end of cycle 2 of a MEM_LAT=3 byte store.
        @(negedge clk);
        chk("rst_mid_pre", 0, o[2], 11'b0);
        store_req[2] = 1'b1;
        size[2]      = 2'b00;
        @(posedge clk);
        #1;
        store_req[2] = 1'b0;
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            chk("rst_mid_run", c, o[2], exp_out(K_RMW, 3, 2'b00, c));
        end
        reset = 1'b1;
        for (int c = 3; c <= 8; c++) begin
            @(negedge clk);
            chk("rst_mid_abort", c, o[2], 11'b0);
            reset = 1'b0;
        end
        run_op("sw_after_rst", 2, 1'b1, 1'b0, 2'b10, K_SW, 0, 3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
